fc_operand_feeder: RTL and testbench

FC_OPERAND_FEEDER -- requirements
Module: fc_operand_feeder

---
 rtl/fc_operand_feeder_if.sv | 43 ++++
 rtl/fc_operand_feeder.sv | 119 +++++++++++
 tb/tb_fc_operand_feeder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_operand_feeder_if.sv
// Operand-feeder bus: job control, node/weight memory read ports, MAC core handshake.
// master = the feeder, slave = the surrounding job controller, memories and MAC core.
interface fc_operand_feeder_if #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH    = 10
);
  // job control
  logic                            i_start;
  logic [ADDR_WIDTH-1:0]           i_num_node;
  logic [ADDR_WIDTH-1:0]           i_node_base;
  logic [ADDR_WIDTH-1:0]           i_wegt_base;
  logic                            i_hold;
  logic                            o_busy;
  logic                            o_done;
  // node memory read port
  logic                            o_node_ce;
  logic [ADDR_WIDTH-1:0]           o_node_addr;
  logic signed [IN_DATA_WIDTH-1:0] i_node_rdata;
  // weight memory read port
  logic                            o_wegt_ce;
  logic [ADDR_WIDTH-1:0]           o_wegt_addr;
  logic signed [IN_DATA_WIDTH-1:0] i_wegt_rdata;
  // MAC core side
  logic                            o_run;
  logic                            o_valid;
  logic signed [IN_DATA_WIDTH-1:0] o_node;
  logic signed [IN_DATA_WIDTH-1:0] o_wegt;
  logic                            i_core_valid;

  modport master (
    input  i_start, i_num_node, i_node_base, i_wegt_base, i_hold,
    input  i_node_rdata, i_wegt_rdata, i_core_valid,
    output o_busy, o_done, o_node_ce, o_node_addr, o_wegt_ce, o_wegt_addr,
    output o_run, o_valid, o_node, o_wegt
  );

  modport slave (
    output i_start, i_num_node, i_node_base, i_wegt_base, i_hold,
    output i_node_rdata, i_wegt_rdata, i_core_valid,
    input  o_busy, o_done, o_node_ce, o_node_addr, o_wegt_ce, o_wegt_addr,
    input  o_run, o_valid, o_node, o_wegt
  );
endinterface

// File: rtl/fc_operand_feeder.sv
// Fully-connected layer operand feeder: streams N node/weight pairs from two
// 1-cycle-latency memories into a MAC core, then waits for the core to drain.
// Optional macro FEEDER_ZERO_SKIP_EN drops pairs with a zero operand.
module fc_operand_feeder #(
  parameter int IN_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH    = 10
) (
  input logic                 clk,
  input logic                 reset,
  fc_operand_feeder_if.master bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] num_node;
  logic [ADDR_WIDTH-1:0] node_base;
  logic [ADDR_WIDTH-1:0] wegt_base;
  logic [ADDR_WIDTH-1:0] k;
  logic [ADDR_WIDTH:0]   d_cnt;     // delivered o_valid pulses
  logic [ADDR_WIDTH:0]   c_cnt;     // i_core_valid pulses seen during the job
  logic                  rd_vld;    // a read was issued last cycle, data is on rdata now

  logic                  issue;
  logic                  deliver;
  logic                  core_hit;
  logic [ADDR_WIDTH:0]   c_next;
  logic [ADDR_WIDTH:0]   d_next;
  logic                  last_k;

  // a read goes out every FETCH cycle the consumer is not holding us off
  assign issue  = (state == FETCH) && !bus.i_hold;
  assign last_k = (k == num_node - 1'b1);

`ifdef FEEDER_ZERO_SKIP_EN
  // pairs with a zero operand contribute nothing to the dot product; drop them
  assign deliver = rd_vld && (bus.i_node_rdata != '0) && (bus.i_wegt_rdata != '0);
`else
  assign deliver = rd_vld;
`endif

  // core results only count while a job is actually in flight
  assign core_hit = bus.i_core_valid && ((state == FETCH) || (state == DRAIN));
  assign c_next   = c_cnt + {{ADDR_WIDTH{1'b0}}, core_hit};
  assign d_next   = d_cnt + {{ADDR_WIDTH{1'b0}}, deliver};

  // job FSM, read index, delivery and completion counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      num_node  <= '0;
      node_base <= '0;
      wegt_base <= '0;
      k         <= '0;
      d_cnt     <= '0;
      c_cnt     <= '0;
      rd_vld    <= 1'b0;
    end else begin
      rd_vld <= issue;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            num_node  <= bus.i_num_node;
            node_base <= bus.i_node_base;
            wegt_base <= bus.i_wegt_base;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          k     <= '0;
          d_cnt <= '0;
          c_cnt <= '0;
          state <= (num_node != '0) ? FETCH : DONE;
        end
        FETCH: begin
          d_cnt <= d_next;
          c_cnt <= c_next;
          if (issue) begin
            if (last_k) state <= DRAIN;
            else        k     <= k + 1'b1;
          end
        end
        DRAIN: begin
          d_cnt <= d_next;
          c_cnt <= c_next;
          // once nothing is in flight d_cnt is final; finish when the core has matched it
          if (!rd_vld && (c_next == d_cnt)) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // status and control outputs decode straight from the state register
  always_comb begin
    bus.o_busy = (state != IDLE);
    bus.o_run  = (state == CLEAR);
    bus.o_done = (state == DONE);
  end

  // read ports: address parked at 0 when no read is issued
  always_comb begin
    bus.o_node_ce   = issue;
    bus.o_wegt_ce   = issue;
    bus.o_node_addr = issue ? (node_base + k) : '0;
    bus.o_wegt_addr = issue ? (wegt_base + k) : '0;
  end

  // operand pair to the MAC core, forced to zero outside valid cycles
  always_comb begin
    bus.o_valid = deliver;
    bus.o_node  = deliver ? bus.i_node_rdata : '0;
    bus.o_wegt  = deliver ? bus.i_wegt_rdata : '0;
  end

endmodule

// File: tb/tb_fc_operand_feeder.sv
// Directed bench for fc_operand_feeder: memory and 2-cycle MAC core models,
// scoreboard queues of expected read addresses and operand pairs.
module tb_fc_operand_feeder;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int MEM = 1 << AW;
`ifdef FEEDER_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {int na; int wa;} addr_t;
  typedef struct {int nv; int wv;} pair_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  fc_operand_feeder_if #(.IN_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  fc_operand_feeder #(.IN_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [DW-1:0] node_mem [MEM];
  logic signed [DW-1:0] wegt_mem [MEM];

  // memories with 1-cycle read latency
  always @(posedge clk) begin
    if (bus.o_node_ce) bus.i_node_rdata <= node_mem[bus.o_node_addr];
    if (bus.o_wegt_ce) bus.i_wegt_rdata <= wegt_mem[bus.o_wegt_addr];
  end

  // MAC core model: clears on o_run, result valid 2 cycles after each pair
  logic [1:0] core_pipe;
  int         acc;
  always @(posedge clk) begin
    if (reset) begin
      core_pipe <= '0;
      acc       <= 0;
    end else begin
      core_pipe <= {core_pipe[0], bus.o_valid};
      if (bus.o_run)        acc <= 0;
      else if (bus.o_valid) acc <= acc + int'(bus.o_node) * int'(bus.o_wegt);
    end
  end
  assign bus.i_core_valid = core_pipe[1];

  int    n_cmp = 0;
  int    n_err = 0;
  addr_t addr_q [$];
  pair_t pair_q [$];
  int    rd_cnt = 0, val_cnt = 0, run_cnt = 0, done_cnt = 0, done_cyc = -1;
  int    exp_res, exp_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // build scoreboard expectations for a job from the memory contents
  task automatic prep(input int n, input int nb, input int wb);
    exp_res = 0;
    exp_val = 0;
    for (int i = 0; i < n; i++) begin
      addr_t a;
      pair_t p;
      a.na = (nb + i) % MEM;
      a.wa = (wb + i) % MEM;
      addr_q.push_back(a);
      p.nv = int'(node_mem[a.na]);
      p.wv = int'(wegt_mem[a.wa]);
      if (!SKIP || (p.nv != 0 && p.wv != 0)) begin
        pair_q.push_back(p);
        exp_res += p.nv * p.wv;
        exp_val++;
      end
    end
  endtask

  task automatic start_job(input int n, input int nb, input int wb);
    @(posedge clk); #1;
    bus.i_start     = 1'b1;
    bus.i_num_node  = AW'(n);
    bus.i_node_base = AW'(nb);
    bus.i_wegt_base = AW'(wb);
    @(posedge clk); #1;
    // scramble job inputs so only the latched copy can be used
    bus.i_start     = 1'b0;
    bus.i_num_node  = AW'(3);
    bus.i_node_base = AW'(16'h155);
    bus.i_wegt_base = AW'(16'h2AA);
  endtask

  task automatic run_job(input string tag, input int n, input int nb, input int wb,
                         input int hold_at, input int hold_len, input int restart_at,
                         input int exp_lat);
    int s, rd0, val0, run0, done0, off;
    prep(n, nb, wb);
    rd0 = rd_cnt; val0 = val_cnt; run0 = run_cnt; done0 = done_cnt;
    start_job(n, nb, wb);
    s = cyc - 1;
    off = 1;
    while (done_cnt == done0 && off < 200) begin
      bus.i_hold  = (off >= hold_at) && (off < hold_at + hold_len);
      bus.i_start = (off == restart_at);
      @(posedge clk); #1;
      off++;
    end
    bus.i_hold  = 1'b0;
    bus.i_start = 1'b0;
    if (done_cnt == done0) chk({tag, "_timeout"}, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_latency"}, done_cyc - s, exp_lat);
    chk({tag, "_done_cnt"}, done_cnt - done0, 1);
    chk({tag, "_run_cnt"}, run_cnt - run0, 1);
    chk({tag, "_reads"}, rd_cnt - rd0, n);
    chk({tag, "_valids"}, val_cnt - val0, exp_val);
    chk({tag, "_result"}, acc, exp_res);
    chk({tag, "_q_left"}, addr_q.size() + pair_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < MEM; i++) begin
      node_mem[i] = '0;
      wegt_mem[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      node_mem[i]         = DW'(i + 1);
      wegt_mem[10'h100 + i] = DW'(i + 5);
    end
    node_mem[10'h3FE] = 8'sd9;
    node_mem[10'h3FF] = -8'sd3;
    for (int i = 0; i < 4; i++) wegt_mem[10'h3F0 + i] = DW'(2 * i + 1);
    for (int i = 0; i < 8; i++) begin
      node_mem[10'h010 + i] = DW'(i - 3);
      wegt_mem[10'h110 + i] = DW'(2 * i + 1);
    end
    node_mem[10'h201] = 8'sd2;
    node_mem[10'h203] = 8'sd4;
    for (int i = 0; i < 4; i++) wegt_mem[10'h300 + i] = 8'sd1;

    bus.i_start = 1'b0; bus.i_hold = 1'b0;
    bus.i_num_node = '0; bus.i_node_base = '0; bus.i_wegt_base = '0;
    bus.i_node_rdata = '0; bus.i_wegt_rdata = '0;

    // scoreboard monitor, sampled on the falling edge
    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          chk("ce_pair", {31'd0, bus.o_node_ce}, {31'd0, bus.o_wegt_ce});
          if (bus.o_node_ce) begin
            rd_cnt++;
            if (addr_q.size() == 0) chk("unexp_read", 1, 0);
            else begin
              addr_t a;
              a = addr_q.pop_front();
              chk("node_addr", 32'(bus.o_node_addr), a.na);
              chk("wegt_addr", 32'(bus.o_wegt_addr), a.wa);
            end
          end
          if (bus.o_valid) begin
            val_cnt++;
            if (pair_q.size() == 0) chk("unexp_valid", 1, 0);
            else begin
              pair_t p;
              p = pair_q.pop_front();
              chk("node_op", int'(bus.o_node), p.nv);
              chk("wegt_op", int'(bus.o_wegt), p.wv);
            end
          end else begin
            chk("ops_zero", 32'({bus.o_node, bus.o_wegt}), 0);
          end
          if (bus.o_run) begin
            run_cnt++;
            chk("run_valid_excl", {31'd0, bus.o_valid}, 0);
          end
          if (bus.o_done) begin
            done_cnt++;
            done_cyc = cyc;
          end
          if (bus.i_hold) chk("hold_no_read", {31'd0, bus.o_node_ce}, 0);
        end
      end
    join_none

    // reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ctl", 32'({bus.o_node_ce, bus.o_wegt_ce, bus.o_run, bus.o_valid, bus.o_busy, bus.o_done}), 0);
    chk("rst_addr", 32'({bus.o_node_addr, bus.o_wegt_addr}), 0);

    run_job("basic", 4, 10'h000, 10'h100, 0, 0, 0, 9);
    chk("basic_70", acc, 70);
    run_job("zero_len", 0, 10'h000, 10'h100, 0, 0, 0, 2);
    run_job("wrap", 4, 10'h3FE, 10'h3F0, 0, 0, 0, 9);
    run_job("hold", 8, 10'h010, 10'h110, 4, 3, 0, 16);
    run_job("busy_start", 4, 10'h000, 10'h100, 0, 0, 3, 9);

    // reset in the middle of FETCH aborts the job
    begin
      int done0;
      prep(8, 10'h010, 10'h110);
      done0 = done_cnt;
      start_job(8, 10'h010, 10'h110);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      addr_q.delete();
      pair_q.delete();
      @(negedge clk);
      chk("abort_ctl", 32'({bus.o_node_ce, bus.o_wegt_ce, bus.o_run, bus.o_valid, bus.o_busy, bus.o_done}), 0);
      chk("abort_addr", 32'({bus.o_node_addr, bus.o_wegt_addr}), 0);
      chk("abort_ops", 32'({bus.o_node, bus.o_wegt}), 0);
      repeat (20) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt - done0, 0);
    end
    run_job("after_abort", 4, 10'h000, 10'h100, 0, 0, 0, 9);

    // zero operands: dropped when skipping is built in, passed through otherwise
    run_job("zero_skip", 4, 10'h200, 10'h300, 0, 0, 0, 9);
    chk("zero_skip_6", acc, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
